decode_ctrl_stage: RTL and testbench

DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

---
 rtl/decode_ctrl_stage.sv | 203 ++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: single-entry registered RV32I(+M) decode/control stage.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   instr_i, valid_i      : upstream instruction word and valid
//   ready_o               : upstream ready (stalls on a load-use hazard)
//   valid_o, ready_i      : downstream handshake for the held entry
//   flush_i               : discards the held entry, drops any incoming word
//   imm_sel_o .. illegal_o: registered decode/control fields of the held entry
//   rd_o, rs1_o, rs2_o    : register fields of the held entry
//   illegal_cnt_o         : saturating count of illegal entries sent downstream
module decode_ctrl_stage #(
  parameter bit          M_EXT = 1'b1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      instr_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             valid_o,
  input  logic             ready_i,
  input  logic             flush_i,
  output logic [2:0]       imm_sel_o,
  output logic [4:0]       alu_op_o,
  output logic [3:0]       br_type_o,
  output logic [3:0]       read_write_o,
  output logic             reg_w_en_o,
  output logic             is_load_o,
  output logic             is_mem_o,
  output logic             muldiv_o,
  output logic             illegal_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic [4:0] alu_op;
    logic [3:0] br_type;
    logic [3:0] read_write;
    logic       reg_w_en;
    logic       is_load;
    logic       is_mem;
    logic       muldiv;
    logic       illegal;
  } dec_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic       legal;
  logic       writes;
  logic       shift;
  dec_t       dec;
  logic       rs1_used;
  logic       rs2_used;
  logic       hazard;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd_f   = instr_i[11:7];
  assign rs1_f  = instr_i[19:15];
  assign rs2_f  = instr_i[24:20];
  assign shift  = (funct3 == 3'd1) || (funct3 == 3'd5);

  always_comb begin
    dec    = '0;
    legal  = 1'b0;
    writes = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        legal       = 1'b1;
        writes      = 1'b1;
        dec.imm_sel = 3'd4;
      end
      OPC_JAL: begin
        legal       = 1'b1;
        writes      = 1'b1;
        dec.imm_sel = 3'd5;
        dec.br_type = 4'd1;
      end
      OPC_JALR: begin
        legal       = (funct3 == 3'd0);
        writes      = 1'b1;
        dec.imm_sel = 3'd1;
        dec.br_type = 4'd2;
      end
      OPC_BRANCH: begin
        legal       = (funct3 != 3'd2) && (funct3 != 3'd3);
        dec.imm_sel = 3'd3;
        dec.br_type = {1'b1, funct3};
      end
      OPC_LOAD: begin
        legal          = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        writes         = 1'b1;
        dec.imm_sel    = 3'd1;
        dec.read_write = {1'b1, funct3};
        dec.is_mem     = 1'b1;
        dec.is_load    = 1'b1;
      end
      OPC_STORE: begin
        legal       = (funct3 <= 3'd2);
        dec.imm_sel = 3'd2;
        dec.is_mem  = 1'b1;
        case (funct3)
          3'd0:    dec.read_write = 4'b1011;
          3'd1:    dec.read_write = 4'b1110;
          default: dec.read_write = 4'b1111;
        endcase
      end
      OPC_OPIMM: begin
        writes      = 1'b1;
        dec.imm_sel = shift ? 3'd6 : 3'd1;
        dec.alu_op  = {funct3, shift & funct7[5], 1'b0};
        if (funct3 == 3'd1)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'd5) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                     legal = 1'b1;
      end
      OPC_OP: begin
        writes     = 1'b1;
        dec.alu_op = {funct3, funct7[5], funct7[0]};
        case (funct7)
          7'b0000000: legal = 1'b1;
          7'b0100000: legal = (funct3 == 3'd0) || (funct3 == 3'd5);
          7'b0000001: begin
            legal      = M_EXT;
            dec.muldiv = M_EXT;
          end
          default:    legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // An illegal word carries no control side effects at all.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end else begin
      dec.reg_w_en = writes && (rd_f != 5'd0);
    end
  end

  // Source usage is judged from the opcode alone, so even illegal words
  // stall conservatively behind a pending load.
  assign rs1_used = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign rs2_used = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};

  assign hazard = valid_o && is_load_o && (rd_o != 5'd0) && valid_i &&
                  ((rs1_used && (rs1_f == rd_o)) || (rs2_used && (rs2_f == rd_o)));

  assign ready_o = (!valid_o || ready_i) && !hazard;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o       <= 1'b0;
      imm_sel_o     <= '0;
      alu_op_o      <= '0;
      br_type_o     <= '0;
      read_write_o  <= '0;
      reg_w_en_o    <= 1'b0;
      is_load_o     <= 1'b0;
      is_mem_o      <= 1'b0;
      muldiv_o      <= 1'b0;
      illegal_o     <= 1'b0;
      rd_o          <= '0;
      rs1_o         <= '0;
      rs2_o         <= '0;
      illegal_cnt_o <= '0;
    end else begin
      if (valid_o && ready_i && !flush_i && illegal_o && (illegal_cnt_o != '1))
        illegal_cnt_o <= illegal_cnt_o + CNT_W'(1);

      if (flush_i) begin
        valid_o <= 1'b0;
      end else if (valid_i && ready_o) begin
        valid_o <= 1'b1;
        {imm_sel_o, alu_op_o, br_type_o, read_write_o,
         reg_w_en_o, is_load_o, is_mem_o, muldiv_o, illegal_o} <= dec;
        rd_o  <= rd_f;
        rs1_o <= rs1_f;
        rs2_o <= rs2_f;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: randomized + directed check of decode_ctrl_stage.
// Two instances share stimulus: dut_a (M_EXT=1, CNT_W=8) and dut_b
// (M_EXT=0, CNT_W=2); both are compared against a behavioural model.
module tb_decode_ctrl_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        valid_in;
  logic        ready_in;
  logic        flush;

  logic       ready_a, valid_a, regw_a, load_a, mem_a, md_a, ill_a;
  logic [2:0] imm_a;
  logic [4:0] alu_a, rd_a, rs1_a, rs2_a;
  logic [3:0] br_a, rw_a;
  logic [7:0] cnt_a;

  logic       ready_b, valid_b, regw_b, load_b, mem_b, md_b, ill_b;
  logic [2:0] imm_b;
  logic [4:0] alu_b, rd_b, rs1_b, rs2_b;
  logic [3:0] br_b, rw_b;
  logic [1:0] cnt_b;

  int unsigned n_cmp;
  int unsigned n_bad;

  decode_ctrl_stage #(.M_EXT(1'b1), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .valid_i(valid_in),
    .ready_o(ready_a), .valid_o(valid_a), .ready_i(ready_in), .flush_i(flush),
    .imm_sel_o(imm_a), .alu_op_o(alu_a), .br_type_o(br_a), .read_write_o(rw_a),
    .reg_w_en_o(regw_a), .is_load_o(load_a), .is_mem_o(mem_a), .muldiv_o(md_a),
    .illegal_o(ill_a), .rd_o(rd_a), .rs1_o(rs1_a), .rs2_o(rs2_a),
    .illegal_cnt_o(cnt_a));

  decode_ctrl_stage #(.M_EXT(1'b0), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .valid_i(valid_in),
    .ready_o(ready_b), .valid_o(valid_b), .ready_i(ready_in), .flush_i(flush),
    .imm_sel_o(imm_b), .alu_op_o(alu_b), .br_type_o(br_b), .read_write_o(rw_b),
    .reg_w_en_o(regw_b), .is_load_o(load_b), .is_mem_o(mem_b), .muldiv_o(md_b),
    .illegal_o(ill_b), .rd_o(rd_b), .rs1_o(rs1_b), .rs2_o(rs2_b),
    .illegal_cnt_o(cnt_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] imm;
    logic [4:0] alu;
    logic [3:0] br;
    logic [3:0] rw;
    logic       regw;
    logic       load;
    logic       mem;
    logic       md;
    logic       ill;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } exp_t;

  typedef enum {K_ILL, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_OPI, K_OP} kind_t;

  // Reference model state: one held word plus per-instance counters.
  bit          m_valid;
  logic [31:0] m_word;
  int unsigned m_cnt_a;
  int unsigned m_cnt_b;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic kind_t classify(input logic [31:0] w, input bit mext);
    logic [2:0] f3;
    logic [6:0] f7;
    kind_t      k;
    f3 = w[14:12];
    f7 = w[31:25];
    k  = K_ILL;
    case (w[6:0])
      7'h37: k = K_LUI;
      7'h17: k = K_AUIPC;
      7'h6F: k = K_JAL;
      7'h67: if (f3 == 0) k = K_JALR;
      7'h63: if (f3 != 2 && f3 != 3) k = K_BR;
      7'h03: if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) k = K_LD;
      7'h23: if (f3 < 3) k = K_ST;
      7'h13: begin
        if (f3 == 1)      begin if (f7 == 0) k = K_OPI; end
        else if (f3 == 5) begin if (f7 == 0 || f7 == 7'h20) k = K_OPI; end
        else              k = K_OPI;
      end
      7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && mext)) k = K_OP;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] w, input bit mext);
    exp_t       e;
    kind_t      k;
    int         f3;
    bit         shift;
    logic [2:0] st_code [3];
    st_code = '{3'b011, 3'b110, 3'b111};
    e     = '0;
    k     = classify(w, mext);
    f3    = int'(w[14:12]);
    shift = (f3 == 1 || f3 == 5);
    e.rd  = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    case (k)
      K_ILL:          e.ill = 1'b1;
      K_LUI, K_AUIPC: e.imm = 3'd4;
      K_JAL:  begin e.imm = 3'd5; e.br = 4'd1; end
      K_JALR: begin e.imm = 3'd1; e.br = 4'd2; end
      K_BR:   begin e.imm = 3'd3; e.br = 4'(8 + f3); end
      K_LD:   begin e.imm = 3'd1; e.rw = 4'(8 + f3); e.mem = 1'b1; e.load = 1'b1; end
      K_ST:   begin e.imm = 3'd2; e.rw = 4'(8 + int'(st_code[f3])); e.mem = 1'b1; end
      K_OPI:  begin
        e.imm = shift ? 3'd6 : 3'd1;
        e.alu = 5'(f3 * 4 + ((shift && w[30]) ? 2 : 0));
      end
      K_OP:   begin
        e.alu = 5'(f3 * 4 + int'(w[30]) * 2 + int'(w[25]));
        e.md  = (w[31:25] == 7'h01);
      end
      default: e.ill = 1'b1;
    endcase
    e.regw = (k inside {K_LUI, K_AUIPC, K_JAL, K_JALR, K_LD, K_OPI, K_OP}) && (w[11:7] != 0);
    return e;
  endfunction

  function automatic bit ref_hazard(input logic [31:0] w, input bit vi);
    bit use1, use2;
    if (!m_valid || !vi) return 1'b0;
    if (!ref_dec(m_word, 1'b1).load || m_word[11:7] == 0) return 1'b0;
    use1 = !(w[6:0] inside {7'h37, 7'h17, 7'h6F});
    use2 = w[6:0] inside {7'h63, 7'h23, 7'h33};
    return (use1 && w[19:15] == m_word[11:7]) || (use2 && w[24:20] == m_word[11:7]);
  endfunction

  function automatic logic [35:0] pack_a();
    return {imm_a, alu_a, br_a, rw_a, regw_a, load_a, mem_a, md_a, ill_a, rd_a, rs1_a, rs2_a};
  endfunction

  function automatic logic [35:0] pack_b();
    return {imm_b, alu_b, br_b, rw_b, regw_b, load_b, mem_b, md_b, ill_b, rd_b, rs1_b, rs2_b};
  endfunction

  task automatic check_outputs();
    check_eq("valid_a", valid_a, m_valid);
    check_eq("valid_b", valid_b, m_valid);
    check_eq("cnt_a", cnt_a, m_cnt_a);
    check_eq("cnt_b", cnt_b, m_cnt_b);
    if (m_valid) begin
      check_eq("dec_a", pack_a(), ref_dec(m_word, 1'b1));
      check_eq("dec_b", pack_b(), ref_dec(m_word, 1'b0));
    end
  endtask

  // One cycle: drive inputs, check ready, clock, advance model, check outputs.
  task automatic step(input logic [31:0] w, input bit vi, input bit ri, input bit fl);
    bit rdy;
    instr = w; valid_in = vi; ready_in = ri; flush = fl;
    #1;
    rdy = (!m_valid || ri) && !ref_hazard(w, vi);
    check_eq("ready_a", ready_a, rdy);
    check_eq("ready_b", ready_b, rdy);
    @(posedge clk);
    if (m_valid && ri && !fl) begin
      if (ref_dec(m_word, 1'b1).ill && m_cnt_a < 255) m_cnt_a++;
      if (ref_dec(m_word, 1'b0).ill && m_cnt_b < 3)   m_cnt_b++;
    end
    if (fl)              m_valid = 1'b0;
    else if (vi && rdy)  begin m_valid = 1'b1; m_word = w; end
    else if (ri)         m_valid = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    valid_in = 1'b0; flush = 1'b0; ready_in = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_a", {valid_a, pack_a(), cnt_a}, '0);
    check_eq("rst_b", {valid_b, pack_b(), cnt_b}, '0);
    m_valid = 1'b0; m_word = '0; m_cnt_a = 0; m_cnt_b = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("rdy_after_rst", {ready_a, ready_b}, 2'b11);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [31:0] w;
    int unsigned k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = ops[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    w[11:7]  = 5'($urandom_range(0, 6));
    w[19:15] = 5'($urandom_range(0, 6));
    w[24:20] = 5'($urandom_range(0, 6));
    if ($urandom_range(0, 19) == 0) w[1:0] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    instr = '0; valid_in = 1'b0; ready_in = 1'b1; flush = 1'b0;
    rst_n = 1'b0;
    m_valid = 1'b0; m_word = '0; m_cnt_a = 0; m_cnt_b = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // add a0,a1,a0
    step(32'h00A58533, 1'b1, 1'b1, 1'b0);
    check_eq("add_fields", {valid_a, regw_a, alu_a, rd_a, ill_a}, {1'b1, 1'b1, 5'd0, 5'd10, 1'b0});

    // lw x5,0(x1); add x6,x5,x2 -> one stall cycle and one bubble
    step(32'h0000A283, 1'b1, 1'b1, 1'b0);
    step(32'h00228333, 1'b1, 1'b1, 1'b0);
    check_eq("hazard_bubble", valid_a, 1'b0);
    step(32'h00228333, 1'b1, 1'b1, 1'b0);
    check_eq("hazard_add_rd", {valid_a, rd_a}, {1'b1, 5'd6});

    // mul a0,a0,a1: legal muldiv with M ext, illegal without
    step(32'h02B50533, 1'b1, 1'b1, 1'b0);
    check_eq("mul_a", {md_a, alu_a, ill_a}, {1'b1, 5'b00001, 1'b0});
    check_eq("mul_b", {ill_b, regw_b, md_b}, {1'b1, 1'b0, 1'b0});
    step(32'h0, 1'b0, 1'b1, 1'b0);
    check_eq("mul_cnt_b", cnt_b, 2'd1);

    // sh x3,2(x4), then stall 3 cycles and flush
    step(32'h00321123, 1'b1, 1'b1, 1'b0);
    check_eq("sh_fields", {rw_a, imm_a, regw_a}, {4'b1110, 3'd2, 1'b0});
    for (int unsigned i = 0; i < 3; i++) step(rand_instr(), 1'b1, 1'b0, 1'b0);
    check_eq("held_sh", {valid_a, rw_a, rd_a}, {1'b1, 4'b1110, 5'd2});
    step(32'h00A58533, 1'b1, 1'b0, 1'b1);
    check_eq("flush_valid", valid_a, 1'b0);
    check_eq("flush_cnt_b", cnt_b, 2'd1);

    // mid-stream reset
    step(32'h00A58533, 1'b1, 1'b1, 1'b0);
    do_reset();

    // saturating counter: five illegal words
    for (int unsigned i = 0; i < 6; i++) begin
      step(32'hFFFFFFFF, i < 5, 1'b1, 1'b0);
      if (i >= 1) check_eq("sat_b", cnt_b, (i >= 3) ? 2'd3 : 2'(i));
    end

    for (int unsigned i = 0; i < 2500; i++) begin
      step(rand_instr(), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);
      if (i == 1200) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
